fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: first fetch address after reset; bits [1:0] SHALL be 00.
REQ-002 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 dHazard  in  1  data hazard from hazard unit: freeze PC and IF/ID.
REQ-005 cHazard  in  1  taken branch: redirect PC and squash IF/ID.
REQ-006 brTarget  in  32  branch target, sampled only when cHazard=1.
REQ-007 imemReq  out  1  instruction memory request.
REQ-008 imemAddr  out  32  registered fetch address.
REQ-009 imemAck  in  1  single-cycle acknowledge; imemData valid in the same cycle.
REQ-010 imemData  in  32  fetched instruction word.
REQ-011 ifidInsnOut  out  32  IF/ID instruction register.
REQ-012 ifidPCOut  out  32  IF/ID register holding fetch address + 4.
REQ-013 ifidValidOut  out  1  IF/ID holds a real instruction.
REQ-014 ifidRSOut / ifidRTOut  out  5 each  ifidInsnOut[25:21] / [20:16], combinational.
REQ-015 dcOp  out  6  ifidInsnOut[31:26], combinational.
REQ-016 stallCount / flushCount  out  16 each  performance counters.

Function
REQ-017 FSM states SHALL be FETCH, HOLD, DROP; imemReq SHALL be 1 in FETCH and DROP, 0 in HOLD.
REQ-018 imemAddr SHALL stay stable while imemReq=1 and imemAck=0; imemAck MAY arrive in the first request cycle.
REQ-019 FETCH, imemAck=1, no hazard: IF/ID loads {imemData, imemAddr+4, valid=1}; PC and imemAddr advance by 4; stay FETCH.
REQ-020 FETCH, imemAck=0, no hazard: IF/ID, PC, imemAddr SHALL hold.
REQ-021 FETCH, dHazard=1, imemAck=1: IF/ID holds; imemData and its address captured in a hold buffer; PC holds; go HOLD.
REQ-022 FETCH, dHazard=1, imemAck=0: everything holds; stay FETCH.
REQ-023 HOLD, dHazard=1: IF/ID and buffer hold. HOLD, dHazard=0: IF/ID loads the buffer with valid=1; PC/imemAddr advance by 4; go FETCH.
REQ-024 cHazard=1 in any state SHALL force next IF/ID insn=0, ifidPC=0, valid=0, and PC := {brTarget[31:2],2'b00}.
REQ-025 cHazard=1 in FETCH with imemAck=1, or in HOLD: imemData or buffer discarded; imemAddr := new PC; go FETCH.
REQ-026 cHazard=1 in FETCH with imemAck=0: go DROP; imemAddr holds the old address until acknowledged.
REQ-027 DROP: on imemAck, data discarded, imemAddr := PC, go FETCH; a further cHazard in DROP updates PC only.
REQ-028 cHazard SHALL take priority over dHazard when both are 1.
REQ-029 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 stallCount SHALL increment every cycle dHazard=1, and flushCount every cycle cHazard=1; each saturates at 16'hFFFF.

Reset
REQ-031 rst=1 SHALL immediately force: state FETCH; PC and imemAddr = RESET_PC; IF/ID insn/PC = 0; valid = 0; hold buffer = 0; both counters = 0.
REQ-032 Reset asserted mid-request or in HOLD/DROP SHALL abandon the transaction; the first cycle after deassertion SHALL present imemReq=1, imemAddr=RESET_PC.

Verification
REQ-033 Reset, then ack every cycle with data 0x8C22_0004: cycle-by-cycle imemAddr 0,4,8; IF/ID {0x8C220004, 4, 1}; ifidRSOut=1, ifidRTOut=2, dcOp=0x23.
REQ-034 dHazard held 3 cycles with ack on its first cycle: IF/ID frozen; state HOLD; imemReq=0; stallCount=3; buffered word enters IF/ID in the cycle after dHazard falls.
REQ-035 cHazard with brTarget=0x0000_0103 and ack pending: DROP entered; old address held until ack; next request at 0x100; IF/ID valid=0, insn 0; flushCount=1.
REQ-036 cHazard and dHazard together in HOLD: buffer discarded; PC = brTarget; state FETCH; both counters increment.
REQ-037 RESET_PC=0xFFFF_FFFC with one ack: next imemAddr = 0x0000_0000, ifidPCOut = 0.
REQ-038 Force stallCount to 0xFFFE, then apply 3 dHazard cycles: counter reads 0xFFFF and stays there; rst asserted mid-DROP clears all per REQ-031.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request channel between the fetch unit and imem.
// Single-cycle acknowledge; data is valid in the ack cycle.
interface fetch_unit_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemAck,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemAck,
        output imemData
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request FSM and the IF/ID register.
// Handles load-use freezes (dHazard) and taken-branch squashes (cHazard).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dHazard,
    input  logic               cHazard,
    input  logic [31:0]        brTarget,
    fetch_unit_if.master       imem,
    output logic [31:0]        ifidInsnOut,
    output logic [31:0]        ifidPCOut,
    output logic               ifidValidOut,
    output logic [4:0]         ifidRSOut,
    output logic [4:0]         ifidRTOut,
    output logic [5:0]         dcOp,
    output logic [15:0]        stallCount,
    output logic [15:0]        flushCount
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_insn_q, buf_insn_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    logic [31:0] br_pc;
    logic [31:0] pc_inc;

    assign br_pc  = {brTarget[31:2], 2'b00};
    assign pc_inc = pc_q + 32'd4;

    // Saturating performance counters, one tick per hazard cycle.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (dHazard && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
        if (cHazard && flush_q != 16'hFFFF) begin
            flush_d = flush_q + 16'd1;
        end
    end

    // Next-state logic: branch redirect wins over the data-hazard freeze.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        insn_d     = insn_q;
        ifpc_d     = ifpc_q;
        valid_d    = valid_q;
        buf_insn_d = buf_insn_q;
        buf_pc_d   = buf_pc_q;

        if (cHazard) begin
            insn_d  = 32'd0;
            ifpc_d  = 32'd0;
            valid_d = 1'b0;
            pc_d    = br_pc;
            case (state_q)
                FETCH: begin
                    if (imem.imemAck) begin
                        addr_d  = br_pc;
                        state_d = FETCH;
                    end else begin
                        // Outstanding request must complete at the old address.
                        state_d = DROP;
                    end
                end
                HOLD: begin
                    buf_insn_d = 32'd0;
                    buf_pc_d   = 32'd0;
                    addr_d     = br_pc;
                    state_d    = FETCH;
                end
                DROP: begin
                    if (imem.imemAck) begin
                        addr_d  = br_pc;
                        state_d = FETCH;
                    end
                end
                default: begin
                    addr_d  = br_pc;
                    state_d = FETCH;
                end
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.imemAck) begin
                        if (dHazard) begin
                            // Park the returned word until the freeze lifts.
                            buf_insn_d = imem.imemData;
                            buf_pc_d   = addr_q;
                            state_d    = HOLD;
                        end else begin
                            insn_d  = imem.imemData;
                            ifpc_d  = addr_q + 32'd4;
                            valid_d = 1'b1;
                            pc_d    = pc_inc;
                            addr_d  = pc_inc;
                        end
                    end
                end
                HOLD: begin
                    if (!dHazard) begin
                        insn_d  = buf_insn_q;
                        ifpc_d  = buf_pc_q + 32'd4;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                        addr_d  = pc_inc;
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (imem.imemAck) begin
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                default: begin
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            insn_q     <= 32'd0;
            ifpc_q     <= 32'd0;
            valid_q    <= 1'b0;
            buf_insn_q <= 32'd0;
            buf_pc_q   <= 32'd0;
            stall_q    <= 16'd0;
            flush_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            insn_q     <= insn_d;
            ifpc_q     <= ifpc_d;
            valid_q    <= valid_d;
            buf_insn_q <= buf_insn_d;
            buf_pc_q   <= buf_pc_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign imem.imemReq  = (state_q != HOLD);
    assign imem.imemAddr = addr_q;

    assign ifidInsnOut  = insn_q;
    assign ifidPCOut    = ifpc_q;
    assign ifidValidOut = valid_q;
    assign ifidRSOut    = insn_q[25:21];
    assign ifidRTOut    = insn_q[20:16];
    assign dcOp         = insn_q[31:26];
    assign stallCount   = stall_q;
    assign flushCount   = flush_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, freeze, branch squash,
// PC wrap and counter saturation, with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        dHazard;
    logic        cHazard;
    logic [31:0] brTarget;
    logic [31:0] ifidInsnOut;
    logic [31:0] ifidPCOut;
    logic        ifidValidOut;
    logic [4:0]  ifidRSOut;
    logic [4:0]  ifidRTOut;
    logic [5:0]  dcOp;
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    logic        dh2;
    logic        ch2;
    logic [31:0] bt2;
    logic [31:0] insn2;
    logic [31:0] pc2;
    logic        valid2;
    logic [4:0]  rs2;
    logic [4:0]  rt2;
    logic [5:0]  op2;
    logic [15:0] sc2;
    logic [15:0] fc2;

    int errors;
    int checks;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .dHazard      (dHazard),
        .cHazard      (cHazard),
        .brTarget     (brTarget),
        .imem         (bus.master),
        .ifidInsnOut  (ifidInsnOut),
        .ifidPCOut    (ifidPCOut),
        .ifidValidOut (ifidValidOut),
        .ifidRSOut    (ifidRSOut),
        .ifidRTOut    (ifidRTOut),
        .dcOp         (dcOp),
        .stallCount   (stallCount),
        .flushCount   (flushCount)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .dHazard      (dh2),
        .cHazard      (ch2),
        .brTarget     (bt2),
        .imem         (bus2.master),
        .ifidInsnOut  (insn2),
        .ifidPCOut    (pc2),
        .ifidValidOut (valid2),
        .ifidRSOut    (rs2),
        .ifidRTOut    (rt2),
        .dcOp         (op2),
        .stallCount   (sc2),
        .flushCount   (fc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        dHazard  = 1'b0;
        cHazard  = 1'b0;
        brTarget = 32'd0;
        bus.imemAck  = 1'b0;
        bus.imemData = 32'd0;
        dh2 = 1'b0;
        ch2 = 1'b0;
        bt2 = 32'd0;
        bus2.imemAck  = 1'b0;
        bus2.imemData = 32'd0;

        #1;
        chk("rst_req", {31'd0, bus.imemReq}, 32'd1);
        chk("rst_addr", bus.imemAddr, 32'd0);
        chk("rst_valid", {31'd0, ifidValidOut}, 32'd0);
        chk("rst_insn", ifidInsnOut, 32'd0);
        chk("rst_stall", {16'd0, stallCount}, 32'd0);
        chk("rst_flush", {16'd0, flushCount}, 32'd0);
        chk("rst_wrap_addr", bus2.imemAddr, 32'hFFFF_FFFC);

        step();
        step();
        rst = 1'b0;
        bus.imemAck   = 1'b1;
        bus.imemData  = 32'h8C22_0004;
        bus2.imemAck  = 1'b1;
        bus2.imemData = 32'h0000_ABCD;
        chk("first_req", {31'd0, bus.imemReq}, 32'd1);
        chk("first_addr", bus.imemAddr, 32'd0);

        // Streaming with ack every cycle.
        step();
        bus2.imemAck = 1'b0;
        chk("s1_addr", bus.imemAddr, 32'd4);
        chk("s1_insn", ifidInsnOut, 32'h8C22_0004);
        chk("s1_pc", ifidPCOut, 32'd4);
        chk("s1_valid", {31'd0, ifidValidOut}, 32'd1);
        chk("s1_rs", {27'd0, ifidRSOut}, 32'd1);
        chk("s1_rt", {27'd0, ifidRTOut}, 32'd2);
        chk("s1_op", {26'd0, dcOp}, 32'h23);
        chk("wrap_addr", bus2.imemAddr, 32'd0);
        chk("wrap_ifpc", pc2, 32'd0);
        chk("wrap_insn", insn2, 32'h0000_ABCD);
        step();
        chk("s2_addr", bus.imemAddr, 32'd8);
        chk("s2_pc", ifidPCOut, 32'd8);
        bus.imemData = 32'h1234_5678;
        step();
        chk("s3_addr", bus.imemAddr, 32'd12);
        chk("s3_insn", ifidInsnOut, 32'h1234_5678);
        chk("s3_op", {26'd0, dcOp}, 32'h04);

        // No ack: everything holds.
        bus.imemAck = 1'b0;
        step();
        chk("wait_addr", bus.imemAddr, 32'd12);
        chk("wait_insn", ifidInsnOut, 32'h1234_5678);
        chk("wait_pc", ifidPCOut, 32'd12);

        // Data hazard for 3 cycles, ack on the first.
        dHazard      = 1'b1;
        bus.imemAck  = 1'b1;
        bus.imemData = 32'hAAAA_5555;
        step();
        bus.imemAck = 1'b0;
        chk("hold_req", {31'd0, bus.imemReq}, 32'd0);
        chk("hold_insn", ifidInsnOut, 32'h1234_5678);
        step();
        step();
        dHazard = 1'b0;
        chk("hold3_req", {31'd0, bus.imemReq}, 32'd0);
        chk("hold3_insn", ifidInsnOut, 32'h1234_5678);
        chk("hold3_stall", {16'd0, stallCount}, 32'd3);
        step();
        chk("rel_insn", ifidInsnOut, 32'hAAAA_5555);
        chk("rel_pc", ifidPCOut, 32'd16);
        chk("rel_valid", {31'd0, ifidValidOut}, 32'd1);
        chk("rel_addr", bus.imemAddr, 32'd16);
        chk("rel_req", {31'd0, bus.imemReq}, 32'd1);

        // Branch with ack pending: DROP.
        cHazard  = 1'b1;
        brTarget = 32'h0000_0103;
        step();
        cHazard = 1'b0;
        chk("drop_req", {31'd0, bus.imemReq}, 32'd1);
        chk("drop_addr", bus.imemAddr, 32'd16);
        chk("drop_valid", {31'd0, ifidValidOut}, 32'd0);
        chk("drop_insn", ifidInsnOut, 32'd0);
        chk("drop_ifpc", ifidPCOut, 32'd0);
        chk("drop_flush", {16'd0, flushCount}, 32'd1);
        step();
        chk("drop2_addr", bus.imemAddr, 32'd16);
        bus.imemAck  = 1'b1;
        bus.imemData = 32'hBAD0_BAD0;
        step();
        bus.imemAck = 1'b0;
        chk("redir_addr", bus.imemAddr, 32'h100);
        chk("redir_valid", {31'd0, ifidValidOut}, 32'd0);
        chk("redir_insn", ifidInsnOut, 32'd0);

        // cHazard and dHazard together while in HOLD.
        dHazard      = 1'b1;
        bus.imemAck  = 1'b1;
        bus.imemData = 32'hDEAD_BEEF;
        step();
        bus.imemAck = 1'b0;
        chk("h2_req", {31'd0, bus.imemReq}, 32'd0);
        cHazard  = 1'b1;
        brTarget = 32'h0000_0200;
        step();
        cHazard = 1'b0;
        dHazard = 1'b0;
        chk("both_req", {31'd0, bus.imemReq}, 32'd1);
        chk("both_addr", bus.imemAddr, 32'h200);
        chk("both_stall", {16'd0, stallCount}, 32'd5);
        chk("both_flush", {16'd0, flushCount}, 32'd2);
        bus.imemAck  = 1'b1;
        bus.imemData = 32'h1111_1111;
        step();
        bus.imemAck = 1'b0;
        chk("after_insn", ifidInsnOut, 32'h1111_1111);
        chk("after_pc", ifidPCOut, 32'h204);
        chk("after_addr", bus.imemAddr, 32'h204);

        // Drive stallCount up to saturation.
        dHazard = 1'b1;
        repeat (65529) @(posedge clk);
        #1;
        chk("sat_fffe", {16'd0, stallCount}, 32'hFFFE);
        step();
        step();
        step();
        dHazard = 1'b0;
        chk("sat_ffff", {16'd0, stallCount}, 32'hFFFF);
        chk("sat_addr", bus.imemAddr, 32'h204);

        // Enter DROP, then reset asynchronously in the middle of it.
        cHazard  = 1'b1;
        brTarget = 32'h0000_0300;
        step();
        cHazard = 1'b0;
        chk("d2_addr", bus.imemAddr, 32'h204);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_addr", bus.imemAddr, 32'd0);
        chk("arst_req", {31'd0, bus.imemReq}, 32'd1);
        chk("arst_stall", {16'd0, stallCount}, 32'd0);
        chk("arst_flush", {16'd0, flushCount}, 32'd0);
        chk("arst_valid", {31'd0, ifidValidOut}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_req", {31'd0, bus.imemReq}, 32'd1);
        chk("post_addr", bus.imemAddr, 32'd0);
        chk("post_pc", ifidPCOut, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
